code_sweep_sequencer: RTL
=========================

Name: code_sweep_sequencer

Overview:
- Upstream stimulus stage for the 2-bit-select / 3-bit-operand decode logic.
- Sweeps every {operand, select} combination and holds each code for a programmable settle time.
- Samples the decoder's 1-bit response for each code and compacts all responses into an 8-bit signature and a ones-count.
- Gives the decoder a registered, glitch-free, fully enumerated input sequence with a start/busy/done handshake.

Parameters:
- HOLD_CYCLES, 2, DRIVE cycles each code is held before sampling; legal range 1..255.
- SEL_W, 2, select width.
- OPND_W, 3, operand width.
- SIG_POLY, 8'h1D, feedback polynomial of the signature compactor.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- resp_in  in  1  decoder response for the current code.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  single-cycle pulse at sweep end.
- sel_out  out  SEL_W  select code to the decoder.
- opnd_out  out  OPND_W  operand code to the decoder.
- sig  out  8  response signature.
- ones_cnt  out  SEL_W+OPND_W+1  number of samples where resp_in was 1.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state IDLE, code 0, hold counter 0.
  - busy 0, done 0, sel_out 0, opnd_out 0, sig 8'h00, ones_cnt 0.
- Code counter: N = SEL_W+OPND_W bits. sel_out = code[SEL_W-1:0]; opnd_out = code[N-1:SEL_W]. Both are registered.
- FSM states:
  - IDLE: outputs hold their last values. If start=1, then next state is DRIVE, code is 0, sig and ones_cnt clear to 0, and hold counter loads HOLD_CYCLES-1.
  - DRIVE: hold counter decrements each cycle. At 0, next state is SAMPLE. The code is held stable for exactly HOLD_CYCLES cycles.
  - SAMPLE, one cycle:
    - sig <= {sig[6:0],1'b0} ^ (sig[7] ? SIG_POLY : 0) ^ {7'b0, resp_in}.
    - ones_cnt <= ones_cnt + resp_in.
    - If code is all ones, next state is DONE. Otherwise code increments and the FSM returns to DRIVE with the hold counter reloaded.
  - DONE, one cycle: done=1, busy=0, then IDLE.
- Latency:
  - Each code occupies HOLD_CYCLES+1 cycles.
  - done rises 2^N·(HOLD_CYCLES+1) cycles after the edge that samples start. With defaults that is 96 cycles.
- Boundaries and simultaneous events:
  - start while busy or in DONE is ignored; no queuing.
  - The code counter never wraps mid-sweep; the all-ones code is the last one sampled.
  - ones_cnt width covers the full 2^N count without overflow.
  - sig and ones_cnt persist after done until the next accepted start.
  - resp_in is ignored outside SAMPLE.
  - Reset asserted mid-sweep aborts immediately to reset values; no done pulse.
- The design must not infer latches: every combinational next-state and next-output path assigns in all branches, and every case has a default.

Optional Feature:
- Macro SWEEP_ABORT_EN.
- With the macro defined:
  - Adds input abort (1 bit) and output aborted (1 bit; reset 0).
  - abort=1 in DRIVE or SAMPLE sends the FSM to IDLE on the next edge. No done pulse is produced, aborted is set to 1, and sig and ones_cnt freeze at their current values.
  - abort takes priority over a SAMPLE-cycle update in the same cycle.
  - aborted clears on the next accepted start.
  - abort in IDLE or DONE has no effect.
- Without the macro: neither port exists and the behaviour is as above.

Decomposition:
- Package sweep_pkg holds:
  - state typedef {IDLE, DRIVE, SAMPLE, DONE}.
  - default SIG_POLY constant.
  - N derivation helper constant.
- Sub-module sig_compactor:
  - 8-bit signature register plus ones counter.
  - Inputs: clr, en, bit_in.
  - Instantiated once.
  - Keeps the FSM file free of compaction arithmetic.

Test Plan:
1. resp_in tied 0, defaults, single start pulse -> busy high 96 cycles, codes 0..31 each held 3 cycles (2 DRIVE + 1 SAMPLE), done pulse, sig=8'h00, ones_cnt=0.
2. resp_in tied 1 -> ones_cnt=32; sig matches a bench reference model of the compactor over 32 ones; done width exactly 1 cycle.
3. resp_in = (sel_out==2'b01) -> ones_cnt=8; sel_out/opnd_out checked against the code sequence every cycle; no change during DRIVE.
4. start re-pulsed at cycles 10 and 50 of a sweep -> ignored; single done at cycle 96; start one cycle after done -> new sweep, sig/ones_cnt clear.
5. rst_n low at cycle 40 mid-sweep -> all outputs return to reset values asynchronously; no done; the next start sweeps from code 0.
6. With SWEEP_ABORT_EN: abort at code 5 during SAMPLE -> IDLE next edge, aborted=1, done stays 0, ones_cnt reflects codes 0..4 only.

Source files
------------

// File: rtl/sweep_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared types and constants for the code sweep sequencer and its signature
// compactor.
//   state_t            : sequencer FSM states (IDLE, DRIVE, SAMPLE, DONE)
//   SIG_POLY_DEFAULT   : default feedback polynomial of the signature register
//   code_width()       : width of the combined {operand, select} code
//   CODE_W_DEFAULT     : code width for the default select/operand widths
// -----------------------------------------------------------------------------
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SIG_POLY_DEFAULT = 8'h1D;

  localparam int SEL_W_DEFAULT  = 2;
  localparam int OPND_W_DEFAULT = 3;

  function automatic int code_width(input int sel_w, input int opnd_w);
    return sel_w + opnd_w;
  endfunction

  localparam int CODE_W_DEFAULT = code_width(SEL_W_DEFAULT, OPND_W_DEFAULT);

endpackage

// File: rtl/sig_compactor.sv
// -----------------------------------------------------------------------------
// sig_compactor
// 8-bit shift/XOR signature register plus a ones counter over a response
// bit stream. Both clear on clr and advance one step whenever en is high.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clr      in   synchronous clear of signature and counter (wins over en)
//   en       in   absorb bit_in this cycle
//   bit_in   in   response bit to compact
//   sig      out  8-bit signature
//   ones_cnt out  count of absorbed 1 bits (CNT_W wide)
// -----------------------------------------------------------------------------
module sig_compactor
  import sweep_pkg::*;
#(
  parameter logic [7:0] SIG_POLY = SIG_POLY_DEFAULT,
  parameter int         CNT_W    = CODE_W_DEFAULT + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [7:0]       sig,
  output logic [CNT_W-1:0] ones_cnt
);

  // Shift left, fold the outgoing MSB back through the polynomial, then
  // inject the new response bit at the LSB.
  function automatic logic [7:0] sig_next(input logic [7:0] s, input logic b);
    return {s[6:0], 1'b0} ^ (s[7] ? SIG_POLY : 8'h00) ^ {7'b0, b};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig      <= 8'h00;
      ones_cnt <= '0;
    end else if (clr) begin
      sig      <= 8'h00;
      ones_cnt <= '0;
    end else if (en) begin
      sig      <= sig_next(sig, bit_in);
      ones_cnt <= ones_cnt + {{(CNT_W-1){1'b0}}, bit_in};
    end
  end

endmodule

// File: rtl/code_sweep_sequencer.sv
// -----------------------------------------------------------------------------
// code_sweep_sequencer
// Drives every {operand, select} code to a downstream decoder, holds each code
// for HOLD_CYCLES cycles, samples the decoder response once per code and
// compacts the responses into a signature and a ones count.
// Optional build macro: SWEEP_ABORT_EN adds the abort input / aborted output.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a sweep (honoured only in IDLE)
//   resp_in  in   decoder response, sampled only in SAMPLE
//   busy     out  high while sweeping (DRIVE/SAMPLE)
//   done     out  one-cycle pulse after the last code is sampled
//   sel_out  out  select part of the current code (registered)
//   opnd_out out  operand part of the current code (registered)
//   sig      out  response signature
//   ones_cnt out  number of sampled responses equal to 1
//   abort    in   (SWEEP_ABORT_EN) cancel the sweep from DRIVE/SAMPLE
//   aborted  out  (SWEEP_ABORT_EN) last sweep was cancelled
// -----------------------------------------------------------------------------
module code_sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int         HOLD_CYCLES = 2,
  parameter int         SEL_W       = SEL_W_DEFAULT,
  parameter int         OPND_W      = OPND_W_DEFAULT,
  parameter logic [7:0] SIG_POLY    = SIG_POLY_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      resp_in,
`ifdef SWEEP_ABORT_EN
  input  logic                      abort,
  output logic                      aborted,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [SEL_W-1:0]          sel_out,
  output logic [OPND_W-1:0]         opnd_out,
  output logic [7:0]                sig,
  output logic [SEL_W+OPND_W:0]     ones_cnt
);

  localparam int            N         = code_width(SEL_W, OPND_W);
  localparam int            CNT_W     = N + 1;
  localparam logic [7:0]    HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [N-1:0]  CODE_LAST = '1;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] code;
  logic [7:0]   hold_cnt;
  logic         accept;
  logic         abort_hit;
  logic         cmp_clr;
  logic         cmp_en;

`ifdef SWEEP_ABORT_EN
  assign abort_hit = abort && ((state == DRIVE) || (state == SAMPLE));
`else
  assign abort_hit = 1'b0;
`endif

  // The code register feeds the decoder directly, so the decoder inputs
  // change only on clock edges.
  assign sel_out  = code[SEL_W-1:0];
  assign opnd_out = code[N-1:SEL_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = DRIVE;
      end
      DRIVE: begin
        if (abort_hit)           state_next = IDLE;
        else if (hold_cnt == '0) state_next = SAMPLE;
      end
      SAMPLE: begin
        if (abort_hit)              state_next = IDLE;
        else if (code == CODE_LAST) state_next = DONE;
        else                        state_next = DRIVE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == DRIVE) || (state == SAMPLE);
    done    = (state == DONE);
    accept  = (state == IDLE) && start;
    cmp_clr = accept;
    // An abort in SAMPLE suppresses that cycle's compaction step.
    cmp_en  = (state == SAMPLE) && !abort_hit;
  end

  // Code and hold counter. Outside an active sweep they simply hold, so the
  // decoder keeps seeing the last code while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code     <= '0;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            code     <= '0;
            hold_cnt <= HOLD_LOAD;
          end
        end
        DRIVE: begin
          if (!abort_hit && (hold_cnt != 8'd0)) hold_cnt <= hold_cnt - 8'd1;
        end
        SAMPLE: begin
          if (!abort_hit && (code != CODE_LAST)) begin
            code     <= code + N'(1);
            hold_cnt <= HOLD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SWEEP_ABORT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aborted <= 1'b0;
    end else if (accept) begin
      aborted <= 1'b0;
    end else if (abort_hit) begin
      aborted <= 1'b1;
    end
  end
`endif

  sig_compactor #(
    .SIG_POLY (SIG_POLY),
    .CNT_W    (CNT_W)
  ) u_sig_compactor (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cmp_clr),
    .en       (cmp_en),
    .bit_in   (resp_in),
    .sig      (sig),
    .ones_cnt (ones_cnt)
  );

endmodule
